// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer
// that drives the serial input of the 1010 sequence detector.
package piso_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_BIT_DIV = 1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_rate_div.sv
// Bit-period divider: counts BIT_DIV cycles per serial bit and raises
// bit_stb_o on the last cycle of each period while enabled.
module piso_serializer_bit_rate_div
    import piso_serializer_pkg::*;
#(
    parameter int unsigned BIT_DIV = DEFAULT_BIT_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic bit_stb_o
);

    localparam int unsigned DW = (clog2(BIT_DIV) < 1) ? 1 : clog2(BIT_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    assign bit_stb_o = en_i && (div_cnt_q == DIV_LAST);

    // A restart wins over counting so a freshly loaded word always gets a full first period.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (restart_i) begin
            div_cnt_d = '0;
        end else if (en_i) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word over valid/ready and shifts
// it out one bit per bit period, supporting zero-gap back-to-back words.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned BIT_DIV   = DEFAULT_BIT_DIV,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             bit_stb_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    logic bit_stb;
    logic final_cycle;
    logic ready_int;
    logic accept;
    logic shifting;
    logic [WIDTH-1:0] sreg_shifted;

    assign shifting    = (state_q == S_SHIFT);
    assign final_cycle = shifting && bit_stb && (bit_cnt_q == BIT_LAST);
    assign ready_int   = (state_q == S_IDLE) || final_cycle;
    assign accept      = in_valid_i && ready_int;

    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    piso_serializer_bit_rate_div #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_rate_div (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (shifting),
        .restart_i (accept),
        .bit_stb_o (bit_stb)
    );

    // Ready is held low while reset is asserted so nothing is offered to upstream mid-reset.
    assign in_ready_o  = ready_int && rst_ni;
    assign ser_valid_o = shifting;
    assign busy_o      = shifting;
    assign bit_stb_o   = bit_stb;
    assign word_done_o = final_cycle;
    assign ser_out_o   = shifting ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]) : IDLE_BIT;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    sreg_d    = in_data_i;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (final_cycle) begin
                    bit_cnt_d = '0;
                    if (accept) begin
                        sreg_d = in_data_i;
                    end else begin
                        state_d = S_IDLE;
                        sreg_d  = sreg_shifted;
                    end
                end else if (bit_stb) begin
                    sreg_d    = sreg_shifted;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: three parameterisations driven by a
// per-cycle vector table plus hand-written multi-cycle sequences.
module tb_piso_serializer;

    logic clk;
    logic rst_n;

    logic [7:0] data_a, data_b;
    logic [3:0] data_c;
    logic valid_a, valid_b, valid_c;
    logic rdy_a, so_a, sv_a, stb_a, done_a, busy_a;
    logic rdy_b, so_b, sv_b, stb_b, done_b, busy_b;
    logic rdy_c, so_c, sv_c, stb_c, done_c, busy_c;

    int checks;
    int errors;

    logic [3:0] hist;
    logic       det_z;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       so;
        logic       sv;
        logic       done;
        logic       z;
    } vec_t;

    vec_t vecs[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .BIT_DIV(1), .IDLE_BIT(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(data_a), .in_valid_i(valid_a),
        .in_ready_o(rdy_a), .ser_out_o(so_a), .ser_valid_o(sv_a), .bit_stb_o(stb_a),
        .word_done_o(done_a), .busy_o(busy_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .BIT_DIV(1), .IDLE_BIT(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(data_b), .in_valid_i(valid_b),
        .in_ready_o(rdy_b), .ser_out_o(so_b), .ser_valid_o(sv_b), .bit_stb_o(stb_b),
        .word_done_o(done_b), .busy_o(busy_b)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .BIT_DIV(3), .IDLE_BIT(1'b0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(data_c), .in_valid_i(valid_c),
        .in_ready_o(rdy_c), .ser_out_o(so_c), .ser_valid_o(sv_c), .bit_stb_o(stb_c),
        .word_done_o(done_c), .busy_o(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Moore 1010 detector fed from the serial output of dut_a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 4'b0000;
        else        hist <= {hist[2:0], so_a};
    end
    assign det_z = (hist == 4'b1010);

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addRow(input logic v, input logic [7:0] d, input logic rdy, input logic so,
                          input logic sv, input logic done, input logic z);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.so = so; r.sv = sv; r.done = done; r.z = z;
        vecs.push_back(r);
    endtask

    task automatic applyStimulus(input vec_t r);
        valid_a = r.v;
        data_a  = r.d;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        valid_a = 1'b1; valid_b = 1'b1; valid_c = 1'b1;
        data_a = 8'hFF; data_b = 8'hFF; data_c = 4'hF;

        // cycle-by-cycle table for dut_a: single word, idle, then back-to-back words
        addRow(1, 8'hA0, 1, 0, 0, 0, 0);
        addRow(0, 8'h00, 0, 1, 1, 0, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 0);
        addRow(0, 8'h00, 0, 1, 1, 0, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 1);
        addRow(0, 8'h00, 0, 0, 1, 0, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 0);
        addRow(0, 8'h00, 1, 0, 1, 1, 0);
        addRow(0, 8'h00, 1, 0, 0, 0, 0);
        addRow(1, 8'hA5, 1, 0, 0, 0, 0);
        addRow(1, 8'h3C, 0, 1, 1, 0, 0);
        addRow(1, 8'h3C, 0, 0, 1, 0, 0);
        addRow(1, 8'h3C, 0, 1, 1, 0, 0);
        addRow(1, 8'h3C, 0, 0, 1, 0, 0);
        addRow(1, 8'h3C, 0, 0, 1, 0, 1);
        addRow(1, 8'h3C, 0, 1, 1, 0, 0);
        addRow(1, 8'h3C, 0, 0, 1, 0, 0);
        addRow(1, 8'h3C, 1, 1, 1, 1, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 1);
        addRow(0, 8'h00, 0, 1, 1, 0, 0);
        addRow(0, 8'h00, 0, 1, 1, 0, 0);
        addRow(0, 8'h00, 0, 1, 1, 0, 0);
        addRow(0, 8'h00, 0, 1, 1, 0, 0);
        addRow(0, 8'h00, 0, 0, 1, 0, 0);
        addRow(0, 8'h00, 1, 0, 1, 1, 0);
        addRow(0, 8'h00, 1, 0, 0, 0, 0);

        // reset held three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_ready_a[%0d]", i), {7'd0, rdy_a}, 8'd0);
            checkOutput($sformatf("reset_sv_a[%0d]", i), {7'd0, sv_a}, 8'd0);
            checkOutput($sformatf("reset_so_a[%0d]", i), {7'd0, so_a}, 8'd0);
            checkOutput($sformatf("reset_ready_c[%0d]", i), {7'd0, rdy_c}, 8'd0);
        end
        rst_n = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready_a", {7'd0, rdy_a}, 8'd1);
        checkOutput("post_reset_sv_a", {7'd0, sv_a}, 8'd0);
        checkOutput("post_reset_ready_b", {7'd0, rdy_b}, 8'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_ready", i), {7'd0, rdy_a}, {7'd0, vecs[i].rdy});
            checkOutput($sformatf("vec%0d_ser_out", i), {7'd0, so_a}, {7'd0, vecs[i].so});
            checkOutput($sformatf("vec%0d_ser_valid", i), {7'd0, sv_a}, {7'd0, vecs[i].sv});
            checkOutput($sformatf("vec%0d_busy", i), {7'd0, busy_a}, {7'd0, vecs[i].sv});
            checkOutput($sformatf("vec%0d_word_done", i), {7'd0, done_a}, {7'd0, vecs[i].done});
            checkOutput($sformatf("vec%0d_det_z", i), {7'd0, det_z}, {7'd0, vecs[i].z});
            @(negedge clk);
        end
        valid_a = 1'b0;

        // LSB-first: 8'h01 gives a single leading 1
        valid_b = 1'b1;
        data_b  = 8'h01;
        checkOutput("lsb_ready", {7'd0, rdy_b}, 8'd1);
        @(negedge clk);
        valid_b = 1'b0;
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("lsb_bit%0d", j), {7'd0, so_b}, (j == 0) ? 8'd1 : 8'd0);
            checkOutput($sformatf("lsb_sv%0d", j), {7'd0, sv_b}, 8'd1);
            checkOutput($sformatf("lsb_done%0d", j), {7'd0, done_b}, (j == 7) ? 8'd1 : 8'd0);
            @(negedge clk);
        end
        checkOutput("lsb_idle_sv", {7'd0, sv_b}, 8'd0);

        // BIT_DIV=3, WIDTH=4, word 4'b1100: each bit held three cycles
        valid_c = 1'b1;
        data_c  = 4'b1100;
        checkOutput("div_ready", {7'd0, rdy_c}, 8'd1);
        @(negedge clk);
        valid_c = 1'b0;
        for (int j = 0; j < 12; j++) begin
            checkOutput($sformatf("div_bit%0d", j), {7'd0, so_c}, (j < 6) ? 8'd1 : 8'd0);
            checkOutput($sformatf("div_sv%0d", j), {7'd0, sv_c}, 8'd1);
            checkOutput($sformatf("div_stb%0d", j), {7'd0, stb_c}, ((j % 3) == 2) ? 8'd1 : 8'd0);
            checkOutput($sformatf("div_done%0d", j), {7'd0, done_c}, (j == 11) ? 8'd1 : 8'd0);
            checkOutput($sformatf("div_ready%0d", j), {7'd0, rdy_c}, (j == 11) ? 8'd1 : 8'd0);
            @(negedge clk);
        end
        checkOutput("div_idle_sv", {7'd0, sv_c}, 8'd0);
        checkOutput("div_idle_stb", {7'd0, stb_c}, 8'd0);

        // reset during the 4th bit of 8'hA5 drops the word without word_done
        valid_a = 1'b1;
        data_a  = 8'hA5;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midword_sv_before", {7'd0, sv_a}, 8'd1);
        checkOutput("midword_bit4", {7'd0, so_a}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_sv", {7'd0, sv_a}, 8'd0);
        checkOutput("async_rst_busy", {7'd0, busy_a}, 8'd0);
        checkOutput("async_rst_so", {7'd0, so_a}, 8'd0);
        checkOutput("async_rst_done", {7'd0, done_a}, 8'd0);
        checkOutput("async_rst_ready", {7'd0, rdy_a}, 8'd0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_hold_done%0d", j), {7'd0, done_a}, 8'd0);
            checkOutput($sformatf("rst_hold_sv%0d", j), {7'd0, sv_a}, 8'd0);
        end
        rst_n   = 1'b1;
        valid_a = 1'b1;
        data_a  = 8'hFF;
        #1;
        checkOutput("rerun_ready", {7'd0, rdy_a}, 8'd1);
        @(negedge clk);
        valid_a = 1'b0;
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("ff_bit%0d", j), {7'd0, so_a}, 8'd1);
            checkOutput($sformatf("ff_sv%0d", j), {7'd0, sv_a}, 8'd1);
            checkOutput($sformatf("ff_done%0d", j), {7'd0, done_a}, (j == 7) ? 8'd1 : 8'd0);
            @(negedge clk);
        end
        checkOutput("ff_idle_sv", {7'd0, sv_a}, 8'd0);
        checkOutput("ff_idle_so", {7'd0, so_a}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
